// File: rtl/ldpc_cw_assembler_pkg.sv
// Shared lengths, chunk counts and FSM state encoding for the LDPC codeword assembler.
package ldpc_pkg;
    localparam int LDPC_WORD_LENGTH = 648;
    localparam int LDPC_INFO_LENGTH = 486;
    localparam int LDPC_PARITY_SIZE = 162;
    localparam int CHUNK_WIDTH      = 27;

    localparam int INFO_CHUNKS = LDPC_INFO_LENGTH / CHUNK_WIDTH;
    localparam int PAR_CHUNKS  = LDPC_PARITY_SIZE / CHUNK_WIDTH;
    localparam int CW_CHUNKS   = INFO_CHUNKS + PAR_CHUNKS;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_PAR = 2'd1,
        EMIT     = 2'd2
    } state_t;
endpackage

// File: rtl/ldpc_cw_assembler_if.sv
// Info/parity input strobes and the chunked codeword output stream of the assembler.
interface ldpc_cw_assembler_if;
    import ldpc_pkg::*;

    logic                        info_valid;
    logic [CHUNK_WIDTH-1:0]      info_data;
    logic                        par_valid;
    logic [LDPC_PARITY_SIZE-1:0] par_data;
    logic                        out_ready;
    logic                        out_valid;
    logic [CHUNK_WIDTH-1:0]      out_data;
    logic                        out_sop;
    logic                        out_last;
    logic                        busy;
    logic                        err;

    modport slave (
        input  info_valid, info_data, par_valid, par_data, out_ready,
        output out_valid, out_data, out_sop, out_last, busy, err
    );

    modport master (
        output info_valid, info_data, par_valid, par_data, out_ready,
        input  out_valid, out_data, out_sop, out_last, busy, err
    );
endinterface

// File: rtl/ldpc_cw_assembler_info_buffer.sv
// Info chunk store: auto-incrementing write pointer, unreset memory, registered read port.
module ldpc_info_buffer
    import ldpc_pkg::*;
#(
    parameter int DEPTH  = INFO_CHUNKS,
    parameter int WIDTH  = CHUNK_WIDTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_clr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        wr_ptr <= '0;
        else if (wr_clr) wr_ptr <= '0;
        else if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
    end
endmodule

// File: rtl/ldpc_cw_assembler.sv
// Collects info chunks and one parity word, then streams the codeword as 27-bit chunks.
// Optional LDPC_ASM_STATS_EN adds a saturating cw_count of completed codewords.
//   state    | meaning
//   COLLECT  | accept info chunks into the buffer
//   WAIT_PAR | info complete, waiting for the encoder parity strobe
//   EMIT     | stream info then parity chunks downstream
module ldpc_cw_assembler #(
    parameter int LDPC_WORD_LENGTH = ldpc_pkg::LDPC_WORD_LENGTH,
    parameter int LDPC_INFO_LENGTH = ldpc_pkg::LDPC_INFO_LENGTH,
    parameter int LDPC_PARITY_SIZE = ldpc_pkg::LDPC_PARITY_SIZE,
    parameter int CHUNK_WIDTH      = ldpc_pkg::CHUNK_WIDTH
) (
    input  logic clk,
    input  logic rst,
`ifdef LDPC_ASM_STATS_EN
    output logic [15:0] cw_count,
`endif
    ldpc_cw_assembler_if.slave bus
);
    localparam int INFO_CHUNKS = LDPC_INFO_LENGTH / CHUNK_WIDTH;
    localparam int CW_CHUNKS   = LDPC_WORD_LENGTH / CHUNK_WIDTH;
    localparam int CNT_W       = $clog2(CW_CHUNKS);

    ldpc_pkg::state_t state, state_nxt;

    logic [CNT_W-1:0]            wr_cnt, rd_cnt, rd_addr, par_idx;
    logic [LDPC_PARITY_SIZE-1:0] par_reg;
    logic [CHUNK_WIDTH-1:0]      buf_rd_data;
    logic                        wr_en, par_load, out_fire, cw_done, err_set, err_q;

    ldpc_info_buffer #(
        .DEPTH (INFO_CHUNKS),
        .WIDTH (CHUNK_WIDTH),
        .ADDR_W(CNT_W)
    ) u_info_buffer (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_clr (cw_done),
        .wr_data(bus.info_data),
        .rd_addr(rd_addr),
        .wr_ptr (wr_cnt),
        .rd_data(buf_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ldpc_pkg::COLLECT;
        else      state <= state_nxt;
    end

    // rd_addr pre-fetches the slot that will be on out_data next cycle, so the
    // registered read port adds no bubble between chunks.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        par_load  = 1'b0;
        out_fire  = 1'b0;
        cw_done   = 1'b0;
        rd_addr   = rd_cnt;
        err_set   = (bus.info_valid && state != ldpc_pkg::COLLECT)
                 || (bus.par_valid  && state != ldpc_pkg::WAIT_PAR)
                 || (bus.info_valid && bus.par_valid);
        case (state)
            ldpc_pkg::COLLECT: begin
                if (bus.info_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt == CNT_W'(INFO_CHUNKS - 1)) state_nxt = ldpc_pkg::WAIT_PAR;
                end
            end
            ldpc_pkg::WAIT_PAR: begin
                if (bus.par_valid) begin
                    par_load  = 1'b1;
                    state_nxt = ldpc_pkg::EMIT;
                end
            end
            ldpc_pkg::EMIT: begin
                if (bus.out_ready) begin
                    out_fire = 1'b1;
                    rd_addr  = rd_cnt + 1'b1;
                    if (rd_cnt == CNT_W'(CW_CHUNKS - 1)) begin
                        cw_done   = 1'b1;
                        state_nxt = ldpc_pkg::COLLECT;
                    end
                end
            end
            default: state_nxt = ldpc_pkg::COLLECT;
        endcase
        if (rd_addr >= CNT_W'(INFO_CHUNKS)) rd_addr = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cw_done)       rd_cnt <= '0;
            else if (out_fire) rd_cnt <= rd_cnt + 1'b1;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (par_load) par_reg <= bus.par_data;
    end

    always_comb begin
        par_idx      = rd_cnt - CNT_W'(INFO_CHUNKS);
        bus.out_data = '0;
        if (state == ldpc_pkg::EMIT) begin
            if (rd_cnt < CNT_W'(INFO_CHUNKS)) bus.out_data = buf_rd_data;
            else bus.out_data = par_reg[par_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
        end
    end

    assign bus.out_valid = (state == ldpc_pkg::EMIT);
    assign bus.out_sop   = bus.out_valid && (rd_cnt == '0);
    assign bus.out_last  = bus.out_valid && (rd_cnt == CNT_W'(CW_CHUNKS - 1));
    assign bus.busy      = (state != ldpc_pkg::COLLECT);
    assign bus.err       = err_q;

`ifdef LDPC_ASM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cw_count <= '0;
        else if (cw_done && cw_count != 16'hFFFF) cw_count <= cw_count + 1'b1;
    end
`endif
endmodule
